// File: rtl/serial_adder_pkg.sv
// Shared FSM state encodings for the bit-serial adder.
package serial_adder_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder reused every cycle by the serial adder.
// Latency: combinational. Backpressure: none.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | ((x | y) & ci);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with carry-in, LSB first through one full-adder cell.
// Latency: out_valid rises WIDTH cycles after the accepting edge; issue interval WIDTH+2.
// Backpressure: result held in DONE until out_ready; operands accepted only in IDLE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             last_bit;

  serial_fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
          sum_sh <= (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign cout      = carry;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 1 and 16.
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- WIDTH=8 instance ----------------
  logic       rst8_n, iv8, ir8, ov8, or8, cin8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [8:0] exp8[$];

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8)
  );

  always @(negedge clk) begin
    if (ov8 && or8) begin
      if (exp8.size() == 0) chk("unexpected_result8", {55'd0, cout8, sum8}, 64'h1ff);
      else chk("result8", {55'd0, cout8, sum8}, {55'd0, exp8.pop_front()});
    end
  end

  // ---------------- WIDTH=1 instance ----------------
  logic rst_n, iv1, ir1, ov1, or1, a1, b1, cin1, sum1, cout1;
  logic [1:0] exp1[$];

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1)
  );

  always @(negedge clk) begin
    if (ov1 && or1) begin
      if (exp1.size() == 0) chk("unexpected_result1", {62'd0, cout1, sum1}, 64'h3);
      else chk("result1", {62'd0, cout1, sum1}, {62'd0, exp1.pop_front()});
    end
  end

  // ---------------- WIDTH=16 instance ----------------
  logic        iv16, ir16, ov16, or16, cin16, cout16;
  logic [15:0] a16, b16, sum16;
  logic [16:0] exp16[$];
  int          acc16 = 0;
  int          res16 = 0;

  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16)
  );

  always @(negedge clk) begin
    if (ov16 && or16) begin
      res16++;
      if (exp16.size() == 0) chk("unexpected_result16", {47'd0, cout16, sum16}, 64'h1ffff);
      else chk("result16", {47'd0, cout16, sum16}, {47'd0, exp16.pop_front()});
    end
  end

  // Present operands, wait for acceptance, then measure accept-to-out_valid latency.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [8:0] e);
    int n;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir8 && n < 50) begin @(negedge clk); n++; end
    if (!ir8) chk("accept8_timeout", 64'd0, 64'd1);
    exp8.push_back(e);
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov8 && n < 40) begin @(negedge clk); n++; end
    chk("latency8", 64'(n), 64'd8);
  endtask

  initial begin
    int n;
    logic took;
    rst8_n = 1'b0; rst_n = 1'b0;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; cin8 = 0;
    iv1 = 0; or1 = 1; a1 = 0; b1 = 0; cin1 = 0;
    iv16 = 0; or16 = 1; a16 = 0; b16 = 0; cin16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready8", 64'(ir8), 64'd1);
    chk("rst_out_valid8", 64'(ov8), 64'd0);
    chk("rst_sum8", 64'(sum8), 64'd0);
    chk("rst_cout8", 64'(cout8), 64'd0);
    chk("rst_in_ready16", 64'(ir16), 64'd1);
    chk("rst_out_valid1", 64'(ov1), 64'd0);
    @(posedge clk); #1;
    rst8_n = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready8", 64'(ir8), 64'd1);
    chk("post_rst_sum8", 64'(sum8), 64'd0);

    // Directed WIDTH=8 vectors
    send8(8'h3C, 8'h5A, 1'b0, 9'h096);
    send8(8'hFF, 8'h01, 1'b0, 9'h100);
    send8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    send8(8'h00, 8'h00, 1'b1, 9'h001);

    // Backpressure: result must hold while out_ready is low, new operands ignored
    @(posedge clk); #1; or8 = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 9'h046);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid8", 64'(ov8), 64'd1);
      chk("bp_sum8", 64'(sum8), 64'h46);
      chk("bp_cout8", 64'(cout8), 64'd0);
      chk("bp_in_ready8", 64'(ir8), 64'd0);
      @(posedge clk); #1;
      iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1; iv8 = 1'b0; or8 = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_back_idle8", 64'(ir8), 64'd1);
    chk("bp_no_extra8", 64'(ov8), 64'd0);

    // Reset during RUN cycle 4 aborts the operation
    @(posedge clk); #1;
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1; iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8_n = 1'b0;
    #1;
    chk("midrst_in_ready8", 64'(ir8), 64'd1);
    chk("midrst_out_valid8", 64'(ov8), 64'd0);
    chk("midrst_sum8", 64'(sum8), 64'd0);
    chk("midrst_cout8", 64'(cout8), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst8_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (ov8) n++; end
    chk("midrst_no_pulse8", 64'(n), 64'd0);
    send8(8'h10, 8'h20, 1'b0, 9'h030);

    // WIDTH=1: single RUN cycle
    @(posedge clk); #1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
    exp1.push_back(2'b11);
    @(posedge clk); #1; iv1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov1 && n < 10) begin @(negedge clk); n++; end
    chk("latency1", 64'(n), 64'd1);
    @(posedge clk); #1;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b1;
    @(negedge clk);
    if (ir1) exp1.push_back(2'b01);
    else chk("accept1", 64'(ir1), 64'd1);
    @(posedge clk); #1; iv1 = 1'b0;

    // WIDTH=16 random traffic with random in_valid/out_ready
    took = 1'b0;
    n = 0;
    while ((acc16 < 1000 || exp16.size() != 0) && n < 60000) begin
      @(posedge clk); #1;
      n++;
      if (took) begin iv16 = 1'b0; took = 1'b0; end
      if (!iv16 && acc16 < 1000 && $urandom_range(0, 3) != 0) begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        iv16 = 1'b1;
      end
      or16 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (iv16 && ir16) begin
        exp16.push_back({1'b0, a16} + {1'b0, b16} + {16'd0, cin16});
        acc16++;
        took = 1'b1;
      end
    end
    @(posedge clk); #1; iv16 = 1'b0;
    if (n >= 60000) chk("random16_timeout", 64'(exp16.size()), 64'd0);
    chk("accepts_vs_results16", 64'(res16), 64'(acc16));
    chk("accepts16", 64'(acc16), 64'd1000);

    n = 0;
    while ((exp8.size() != 0 || exp1.size() != 0) && n < 50) begin @(negedge clk); n++; end
    chk("drain8", 64'(exp8.size()), 64'd0);
    chk("drain1", 64'(exp1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
